pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers and the PC-source select.
- Resolves three hazard classes: load-use data hazard, taken branch resolved in MEM, and multi-cycle data-memory access.
- Sits beside the datapath; consumes ID, EX and MEM stage fields plus the data-memory ready handshake.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl_haz_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned MAX_MEM_WAIT_DEF = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage fields into, and pipeline register controls out of, the hazard sequencer.
interface pipe_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_uses_rt;
  logic       EX_mem_read;
  logic [4:0] EX_mux_out;
  logic       MEM_branch;
  logic       MEM_zero;
  logic       MEM_mem_read;
  logic       MEM_mem_write;
  logic       MEM_ready;
  logic       pc_write;
  logic       pc_sel;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       pipe_hold;
  logic       mem_timeout;

  modport master (
    output ID_rs, ID_rt, ID_uses_rt, EX_mem_read, EX_mux_out,
           MEM_branch, MEM_zero, MEM_mem_read, MEM_mem_write, MEM_ready,
    input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_hold, mem_timeout
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rt, EX_mem_read, EX_mux_out,
           MEM_branch, MEM_zero, MEM_mem_read, MEM_mem_write, MEM_ready,
    output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_hold, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Combinational hazard conditions: load-use, taken branch, data-memory busy.
module haz_detect
  import pipe_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_branch,
  input  logic       i_mem_zero,
  input  logic       i_mem_read,
  input  logic       i_mem_write,
  input  logic       i_mem_ready,
  output logic       o_lduse,
  output logic       o_taken,
  output logic       o_mem_busy
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = (i_ex_rd == i_id_rs);
  assign w_rt_hit   = i_id_uses_rt & (i_ex_rd == i_id_rt);
  assign o_lduse    = i_ex_mem_read & (i_ex_rd != REG_ZERO) & (w_rs_hit | w_rt_hit);
  assign o_taken    = i_mem_branch & i_mem_zero;
  assign o_mem_busy = (i_mem_read | i_mem_write) & ~i_mem_ready;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / FLUSH / MEM_WAIT).
// HAZ_PERF_CNT_EN adds saturating stall/flush/wait performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = MAX_MEM_WAIT_DEF,
  parameter int unsigned WAIT_W       = 4
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic clk,
  input  logic startin,
  pipe_hazard_ctrl_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] wait_cycles
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_set;

  logic w_lduse;
  logic w_taken;
  logic w_mem_busy;
  logic w_eval;
  logic w_stall;
  logic w_flush;
  logic w_hold;
  logic w_pc_write;
  logic w_pc_sel;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;

  haz_detect u_haz_detect (
    .i_id_rs       (bus.ID_rs),
    .i_id_rt       (bus.ID_rt),
    .i_id_uses_rt  (bus.ID_uses_rt),
    .i_ex_mem_read (bus.EX_mem_read),
    .i_ex_rd       (bus.EX_mux_out),
    .i_mem_branch  (bus.MEM_branch),
    .i_mem_zero    (bus.MEM_zero),
    .i_mem_read    (bus.MEM_mem_read),
    .i_mem_write   (bus.MEM_mem_write),
    .i_mem_ready   (bus.MEM_ready),
    .o_lduse       (w_lduse),
    .o_taken       (w_taken),
    .o_mem_busy    (w_mem_busy)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait;
    w_timeout_set  = 1'b0;
    w_eval         = 1'b0;
    w_stall        = 1'b0;
    w_flush        = 1'b0;
    w_hold         = 1'b0;
    w_pc_write     = 1'b1;
    w_pc_sel       = 1'b0;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;

    if (startin) begin
      w_state_nxt    = RUN;
      w_wait_nxt     = '0;
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else begin
      // Memory wait outranks everything; branch/load-use only resolved when
      // the MEM stage can advance (w_eval), and never in the FLUSH shadow.
      unique case (r_state)
        RUN, FLUSH: begin
          w_state_nxt = RUN;
          if (w_mem_busy) begin
            w_hold      = 1'b1;
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end else begin
            w_eval = (r_state == RUN);
          end
        end
        MEM_WAIT: begin
          if (w_mem_busy) begin
            if (r_wait == WAIT_W'(MAX_MEM_WAIT)) begin
              w_timeout_set = 1'b1;
              w_state_nxt   = RUN;
              w_wait_nxt    = '0;
            end else begin
              w_hold     = 1'b1;
              w_wait_nxt = r_wait + WAIT_W'(1);
            end
          end else begin
            w_eval      = 1'b1;
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
          end
        end
        default: w_state_nxt = RUN;
      endcase

      if (w_hold) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
      end

      if (w_eval) begin
        if (w_taken) begin
          w_flush        = 1'b1;
          w_pc_sel       = 1'b1;
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
          w_ex_mem_flush = 1'b1;
          w_state_nxt    = FLUSH;
        end else if (w_lduse) begin
          w_stall       = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.pipe_hold    = w_hold;
  assign bus.mem_timeout  = r_timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (startin) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_hold  && (r_wait_cnt  != '1)) r_wait_cnt  <= r_wait_cnt  + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;
  assign wait_cycles  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (one vector per clock cycle).
module tb_pipe_hazard_ctrl;

  // Expected output bits: {pc_write, pc_sel, if_id_write, if_id_flush,
  //                        id_ex_flush, ex_mem_flush, pipe_hold, mem_timeout}
  localparam logic [7:0] DEF = 8'b1010_0000;
  localparam logic [7:0] RST = 8'b0001_1100;
  localparam logic [7:0] STL = 8'b0000_1000;
  localparam logic [7:0] TKN = 8'b1111_1100;
  localparam logic [7:0] HLD = 8'b0000_0010;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       exmr;
    logic [4:0] exrd;
    logic       br;
    logic       z;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic startin;
  int   errors;
  int   checks;
  vec_t tbl[28];

  pipe_hazard_ctrl_if bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  logic [15:0] wait_cycles;
`endif

  pipe_hazard_ctrl #(
    .MAX_MEM_WAIT (15),
    .WAIT_W       (4)
  ) dut (
    .clk          (clk),
    .startin      (startin),
    .bus          (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .wait_cycles  (wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic rst, logic [4:0] rs, logic [4:0] rt,
                              logic urt, logic exmr, logic [4:0] exrd, logic br, logic z,
                              logic mr, logic mw, logic rdy, logic [7:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt;
    v.exmr = exmr; v.exrd = exrd; v.br = br; v.z = z;
    v.mr = mr; v.mw = mw; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    startin           = v.rst;
    bus.ID_rs         = v.rs;
    bus.ID_rt         = v.rt;
    bus.ID_uses_rt    = v.urt;
    bus.EX_mem_read   = v.exmr;
    bus.EX_mux_out    = v.exrd;
    bus.MEM_branch    = v.br;
    bus.MEM_zero      = v.z;
    bus.MEM_mem_read  = v.mr;
    bus.MEM_mem_write = v.mw;
    bus.MEM_ready     = v.rdy;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {bus.pc_write, bus.pc_sel, bus.if_id_write, bus.if_id_flush,
           bus.id_ex_flush, bus.ex_mem_flush, bus.pipe_hold, bus.mem_timeout};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive on the falling edge, sample mid-cycle before the next rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    check(v.name, v.exp);
  endtask

  initial begin
    vec_t v;
    errors = 0;
    checks = 0;
    drive(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST));

    //              name                rst rs rt urt exmr exrd br z mr mw rdy exp
    tbl[0]  = mk("reset",             1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
    tbl[1]  = mk("idle",              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    tbl[2]  = mk("lduse_rs",          0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, STL);
    tbl[3]  = mk("after_stall",       0, 8, 0, 0, 0, 8, 0, 0, 0, 0, 0, DEF);
    tbl[4]  = mk("zero_reg",          0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, DEF);
    tbl[5]  = mk("rt_unused",         0, 1, 9, 0, 1, 9, 0, 0, 0, 0, 0, DEF);
    tbl[6]  = mk("lduse_rt",          0, 1, 9, 1, 1, 9, 0, 0, 0, 0, 0, STL);
    tbl[7]  = mk("taken_lduse",       0, 8, 0, 0, 1, 8, 1, 1, 0, 0, 0, TKN);
    tbl[8]  = mk("flush_cycle",       0, 8, 0, 0, 1, 8, 1, 1, 0, 0, 0, DEF);
    tbl[9]  = mk("not_taken",         0, 8, 0, 0, 1, 8, 1, 0, 0, 0, 0, STL);
    tbl[10] = mk("wait1",             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[11] = mk("wait2",             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[12] = mk("wait3",             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[13] = mk("ready",             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, DEF);
    tbl[14] = mk("idle2",             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    tbl[15] = mk("busy_vs_taken",     0, 8, 0, 0, 1, 8, 1, 1, 0, 1, 0, HLD);
    tbl[16] = mk("ready_taken",       0, 8, 0, 0, 1, 8, 1, 1, 0, 1, 1, TKN);
    tbl[17] = mk("flush_after_wait",  0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, DEF);
    tbl[18] = mk("lduse_run",         0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, STL);
    tbl[19] = mk("taken2",            0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, TKN);
    tbl[20] = mk("flush_busy",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[21] = mk("wait_f",            0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[22] = mk("rst_in_wait",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RST);
    tbl[23] = mk("busy_after_rst",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLD);
    tbl[24] = mk("ready2",            0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, DEF);
    tbl[25] = mk("wait_ld",           0, 8, 0, 0, 1, 8, 0, 0, 1, 0, 0, HLD);
    tbl[26] = mk("ready_lduse",       0, 8, 0, 0, 1, 8, 0, 0, 1, 0, 1, STL);
    tbl[27] = mk("idle3",             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);

    for (int i = 0; i < 28; i++) step(tbl[i]);

    // Partial wait, then reset: the following wait must still last the full 15 cycles.
    for (int i = 0; i < 10; i++) step(mk("pre_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLD));
    step(mk("rst_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST));

    // Timeout: 15 hold cycles, release on the 16th, flag visible from the next cycle.
    for (int i = 0; i < 15; i++) step(mk("to_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLD));
    step(mk("to_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEF));
    step(mk("to_rewait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLD | 8'b0000_0001));
    step(mk("to_sticky1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF | 8'b0000_0001));
    step(mk("to_sticky2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF | 8'b0000_0001));
    step(mk("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST | 8'b0000_0001));
    step(mk("to_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));

`ifdef HAZ_PERF_CNT_EN
    checks++;
    if ({stall_cycles, flush_events, wait_cycles} !== 48'd0) begin
      errors++;
      $display("FAIL perf_clear: got %0d/%0d/%0d expected 0/0/0",
               stall_cycles, flush_events, wait_cycles);
    end
`endif

    v = mk("end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    drive(v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
